// File: rtl/m_memarb.sv
// Single-port RAM arbiter between instruction fetch (IF) and data access (MEM).
// MEM has priority; a starvation counter hands IF the next conflict after STARVE_MAX refusals.
module m_memarb #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_i_req,
  input  logic [ADDR_W-1:0] w_i_addr,
  output logic              w_i_gnt,
  output logic              r_i_valid,
  output logic [DATA_W-1:0] w_i_rdata,
  input  logic              w_d_req,
  input  logic              w_d_we,
  input  logic [ADDR_W-1:0] w_d_addr,
  input  logic [DATA_W-1:0] w_d_din,
  output logic              w_d_gnt,
  output logic              r_d_valid,
  output logic [DATA_W-1:0] w_d_rdata,
  output logic              w_stall,
  output logic [ADDR_W-1:0] w_m_addr,
  output logic              w_m_we,
  output logic [DATA_W-1:0] w_m_din,
  input  logic [DATA_W-1:0] w_m_dout,
  output logic [31:0]       r_conflicts
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0] r_starve;
  logic       w_i_prio;

  assign w_i_prio = (r_starve == StarveMax);

  // Reset masks both grants, which also keeps w_m_we low during reset.
  assign w_d_gnt = ~w_rst & w_d_req & ~(w_i_req & w_i_prio);
  assign w_i_gnt = ~w_rst & w_i_req & ~w_d_gnt;
  assign w_stall = w_i_req & ~w_i_gnt;

  always_comb begin
    w_m_addr = w_i_addr;
    w_m_we   = 1'b0;
    w_m_din  = '0;
    if (w_d_gnt) begin
      w_m_addr = w_d_addr;
      w_m_we   = w_d_we;
      w_m_din  = w_d_din;
    end
  end

  assign w_i_rdata = r_i_valid ? w_m_dout : '0;
  assign w_d_rdata = r_d_valid ? w_m_dout : '0;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_i_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_starve    <= 4'd0;
      r_conflicts <= 32'd0;
    end else begin
      r_i_valid <= w_i_gnt;
      r_d_valid <= w_d_gnt & ~w_d_we;
      if (w_i_gnt) begin
        r_starve <= 4'd0;
      end else if (w_i_req && (r_starve != StarveMax)) begin
        r_starve <= r_starve + 4'd1;
      end
      if (w_i_req && w_d_req) begin
        r_conflicts <= r_conflicts + 32'd1;
      end
    end
  end

endmodule
